// File: rtl/bsg_dff_negedge_pkg.sv
// Shared definitions for the falling-edge elastic pipeline and its stages.
package bsg_dff_negedge_pkg;

  // Default data width used when a parent does not override width_p.
  localparam int unsigned default_width_lp = 16;

  // Default value loaded into every data stage while reset is asserted.
  localparam logic [63:0] default_reset_val_lp = 64'h0;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int count_width_f(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bsg_dff_negedge_reset_en_stage.sv
// One pipeline stage: a falling-edge data register with load enable and an
// associated valid bit. Data only changes on load, so an empty stage keeps
// its last value and never picks up X after reset.
module bsg_dff_negedge_reset_en_stage
  import bsg_dff_negedge_pkg::*;
#(
  parameter int                 width_p     = default_width_lp,
  parameter logic [width_p-1:0] reset_val_p = width_p'(default_reset_val_lp)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               load_i,   // take data_i; stage becomes valid
  input  logic               free_i,   // current entry leaves (or stage empty)
  input  logic               clear_i,  // synchronous flush of the valid bit
  input  logic [width_p-1:0] data_i,
  output logic               valid_o,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_q, data_d;
  logic               valid_q, valid_d;

  // Next-state: clear beats load, load beats drain, otherwise hold.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d = data_i;
    end
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
    end else if (free_i) begin
      valid_d = 1'b0;
    end
  end

  // Falling-edge state register with asynchronous active-low reset.
  always_ff @(negedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_q  <= reset_val_p;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/bsg_dff_negedge_reset_pipe.sv
// Elastic pipeline of falling-edge registers with per-stage valids, bubble
// collapse, synchronous flush and an occupancy count.
//
// Handshake: upstream transfers data_i on a falling edge where
// valid_i & ready_o; ready_o never depends on valid_i. Downstream consumes
// data_o by raising yumi_i, which is only legal while valid_o is high, and
// may depend combinationally on valid_o/data_o.
module bsg_dff_negedge_reset_pipe
  import bsg_dff_negedge_pkg::*;
#(
  parameter int                 width_p     = default_width_lp,
  parameter int                 depth_p     = 2,
  parameter logic [width_p-1:0] reset_val_p = width_p'(default_reset_val_lp)
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic                                flush_i,
  input  logic                                valid_i,
  input  logic [width_p-1:0]                  data_i,
  output logic                                ready_o,
  output logic                                valid_o,
  output logic [width_p-1:0]                  data_o,
  input  logic                                yumi_i,
  output logic [count_width_f(depth_p)-1:0]   count_o
);

  localparam int cnt_w_lp = count_width_f(depth_p);

  logic [depth_p-1:0] stage_v;
  logic [depth_p-1:0] stage_free;
  logic [depth_p-1:0] stage_load;
  logic [width_p-1:0] stage_data [depth_p];

  logic                accept;
  logic                consume;
  logic [cnt_w_lp-1:0] count_q, count_d;

  // Free chain: a stage can take new data if it is empty or its entry moves on.
  always_comb begin
    stage_free = '0;
    stage_free[depth_p-1] = ~stage_v[depth_p-1] | yumi_i;
    for (int k = depth_p - 2; k >= 0; k--) begin
      stage_free[k] = ~stage_v[k] | stage_free[k+1];
    end
  end

  assign ready_o = stage_free[0] & ~flush_i;
  assign accept  = valid_i & ready_o;
  assign consume = stage_v[depth_p-1] & yumi_i & ~flush_i;

  // Advance: a free stage loads from its valid predecessor; flush freezes data.
  always_comb begin
    stage_load    = '0;
    stage_load[0] = accept;
    for (int k = 1; k < depth_p; k++) begin
      stage_load[k] = stage_free[k] & stage_v[k-1] & ~flush_i;
    end
  end

  for (genvar k = 0; k < depth_p; k++) begin : g_stage
    logic [width_p-1:0] stage_in;

    if (k == 0) begin : g_head
      assign stage_in = data_i;
    end else begin : g_body
      assign stage_in = stage_data[k-1];
    end

    bsg_dff_negedge_reset_en_stage #(
      .width_p     (width_p),
      .reset_val_p (reset_val_p)
    ) u_stage (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .load_i    (stage_load[k]),
      .free_i    (stage_free[k]),
      .clear_i   (flush_i),
      .data_i    (stage_in),
      .valid_o   (stage_v[k]),
      .data_o    (stage_data[k])
    );
  end

  // Occupancy: +1 on accept, -1 on consume, zero on flush.
  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (accept && !consume) begin
      count_d = count_q + 1'b1;
    end else if (consume && !accept) begin
      count_d = count_q - 1'b1;
    end
  end

  // Occupancy register, cleared asynchronously with the stages.
  always_ff @(negedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign valid_o = stage_v[depth_p-1];
  assign data_o  = stage_data[depth_p-1];
  assign count_o = count_q;

  // Population count of the stage valids, used to cross-check count_q.
  logic [cnt_w_lp-1:0] occupancy;
  always_comb begin
    occupancy = '0;
    for (int k = 0; k < depth_p; k++) begin
      occupancy = occupancy + cnt_w_lp'(stage_v[k]);
    end
  end

  a_yumi_needs_valid : assert property (
    @(negedge clk_i) disable iff (!reset_n_i) yumi_i |-> valid_o);

  a_count_matches_valids : assert property (
    @(negedge clk_i) disable iff (!reset_n_i) count_q == occupancy);

  a_depth_legal : assert property (@(negedge clk_i) depth_p >= 1);

  a_width_legal : assert property (@(negedge clk_i) width_p >= 1);

endmodule

// File: doc/bsg_dff_negedge_reset_pipe.md
Name: bsg_dff_negedge_reset_pipe

Overview:
- Parametrised elastic pipeline of falling-edge-clocked registers with per-stage valid bits, valid/ready handshake and bubble collapse.
- Successor to the fixed single-stage negedge reset DFF; generalises width, depth and reset value, and adds flow control and flush.
- Used to retime data into half-cycle domains, such as SRAM or IO launch paths, without giving up back-pressure.

Parameters:
- width_p, 16, data width in bits; must be >= 1.
- depth_p, 2, number of register stages; must be >= 1.
- reset_val_p, 0, value loaded into every data stage on reset; width_p bits.

Ports:
- clk_i  input  1  clock; all state updates on the falling edge.
- reset_n_i  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous flush; discards all in-flight entries.
- valid_i  input  1  upstream data valid.
- data_i  input  width_p  upstream data.
- ready_o  output  1  pipeline can accept data_i this cycle.
- valid_o  output  1  last stage holds valid data.
- data_o  output  width_p  last stage data.
- yumi_i  input  1  downstream consumes data_o; legal only when valid_o=1.
- count_o  output  $clog2(depth_p+1)  number of occupied stages.

Behaviour:
- Reset:
  - reset_n_i=0 immediately, with no clock required, sets all stage valids to 0, all data stages to reset_val_p, and count_o to 0.
  - Outputs during reset: valid_o=0, data_o=reset_val_p, ready_o=1 (except when flush_i=1).
  - Deassertion is sampled on the next falling edge.
- Stages are numbered 0 (input) to depth_p-1 (output). Let v[k] be the stage valid and adv[k] mean stage k loads from stage k-1 (or from input, for k=0).
  - Stage depth_p-1 is free when ~v[depth_p-1] | yumi_i.
  - Stage k<depth_p-1 is free when ~v[k] | (stage k+1 free).
- Handshake and bubble collapse:
  - ready_o = stage 0 free & ~flush_i.
  - Input is accepted on a falling edge when valid_i & ready_o.
  - An entry moves forward whenever the next stage is free, so bubbles collapse.
  - A stalled pipeline holds data and valid unchanged.
- Data of a stage whose valid is 0 is don't-care to consumers but must hold its last value; no X propagation after reset.
- Latency:
  - An entry accepted at falling edge n into an empty pipeline appears on valid_o/data_o after falling edge n+depth_p-1.
  - depth_p=1 gives single negedge latency.
- Throughput: one entry per clock when yumi_i is held high. No bubble is inserted when full and yumi_i=1 in the same cycle.
- Full: count_o=depth_p and yumi_i=0 ⇒ ready_o=0.
- Empty: valid_o=0; yumi_i is ignored (assertion flags it).
- flush_i=1 at a falling edge:
  - all v[k] cleared and count_o becomes 0;
  - input is not accepted (ready_o=0 while flush_i=1);
  - yumi_i has no additional effect;
  - data stages hold their values.
- count_o update:
  - +1 on accept;
  - -1 on a valid_o & yumi_i consume;
  - unchanged when both or neither occur;
  - 0 on flush or reset.
- Reset mid-stream: all entries are lost asynchronously; there is no partial update on the edge where reset is released.
- Assertions (simulation only):
  - yumi_i without valid_o;
  - depth_p < 1;
  - width_p < 1.

Decomposition:
- Shared package bsg_dff_negedge_pkg holds:
  - a function computing the count width, $clog2(depth_p+1);
  - a localparam for the default reset value.
- Natural sub-module: bsg_dff_negedge_reset_en_stage, one width_p-bit negedge register with async active-low reset to reset_val_p, a load enable, and a valid bit with sync clear.
- The top instantiates depth_p stages via generate and computes the free/advance chain plus count_o.

Test Plan:
- Reset release, width_p=16, depth_p=2, reset_val_p=16'hA5A5:
  - pulse reset_n_i low between edges → data_o=16'hA5A5 immediately, valid_o=0, count_o=0, ready_o=1.
- Latency, yumi_i=1:
  - send 16'h0001,16'h0002,16'h0003 on consecutive falling edges → valid_o rises after edge n+1;
  - data_o shows 1,2,3 on consecutive cycles;
  - count_o never exceeds 2.
- Back-pressure, yumi_i=0:
  - send 16'h1111,16'h2222,16'h3333 → first two accepted, count_o=2, ready_o=0, 16'h3333 held by upstream;
  - raise yumi_i → 16'h1111 consumed and 16'h3333 accepted on the same edge, count_o stays 2.
- Bubble collapse, depth_p=4:
  - insert 16'hBEEF, idle one cycle, insert 16'hCAFE, with yumi_i=0 throughout → both end in stages 3 and 2, count_o=2, no gap.
- Flush with valid_i=1 and count_o=3 → count_o=0, valid_o=0, input not accepted, data_o unchanged.
- Async reset mid-stream with count_o=3, depth_p=4 → valid_o=0 and data_o=reset_val_p before the next clock edge.
